// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and mmu word-port bundle for load_store_unit
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wr_data;
    logic        rsp_valid;
    logic [31:0] rsp_rd_data;
    logic        rsp_err;
    logic [31:0] mmu_addr;
    logic        mmu_wr_ena;
    logic [31:0] mmu_wr_data;
    logic [31:0] mmu_rd_data;

    // Core datapath plus mmu side of the bundle.
    modport master (
        output req_valid, req_wr, req_funct3, req_addr, req_wr_data, mmu_rd_data,
        input  req_ready, rsp_valid, rsp_rd_data, rsp_err, mmu_addr, mmu_wr_ena, mmu_wr_data
    );

    // The load/store sequencer itself.
    modport slave (
        input  req_valid, req_wr, req_funct3, req_addr, req_wr_data, mmu_rd_data,
        output req_ready, rsp_valid, rsp_rd_data, rsp_err, mmu_addr, mmu_wr_ena, mmu_wr_data
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store to whole-word mmu access sequencer with read-modify-write
module load_store_unit #(
    parameter int RD_WAIT = 0
) (
    input  logic              clk,
    input  logic              rstb,
    load_store_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [7:0] WAIT_LAST = RD_WAIT[7:0];

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic        wr_q;
    logic [7:0]  wait_cnt;
    logic [31:0] mmu_addr_q;
    logic [31:0] mmu_wr_data_q;
    logic        mmu_wr_ena_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rd_data_q;
    logic        req_err;

    // Pick the addressed byte/half out of the fetched word and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] f3,
                                                 input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return w;
        endcase
    endfunction

    // Overlay the store data onto the fetched word at the addressed lane.
    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                                input logic [2:0] f3, input logic [1:0] a);
        logic [31:0] r;
        r = w;
        if (f3 == 3'b000) begin
            case (a)
                2'd0:    r[7:0]   = d[7:0];
                2'd1:    r[15:8]  = d[7:0];
                2'd2:    r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end else if (f3 == 3'b001) begin
            if (a[1]) r[31:16] = d[15:0];
            else      r[15:0]  = d[15:0];
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Misalignment and illegal-encoding check on the live request fields.
    always_comb begin
        req_err = 1'b0;
        case (bus.req_funct3)
            3'b000:         req_err = 1'b0;
            3'b001:         req_err = bus.req_addr[0];
            3'b010:         req_err = |bus.req_addr[1:0];
            3'b100, 3'b101: req_err = bus.req_wr | (bus.req_funct3[0] & bus.req_addr[0]);
            default:        req_err = 1'b1;
        endcase
    end

    // Sequencer: accept, read with optional wait, optional write, one-cycle response.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state         <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            f3_q          <= '0;
            wr_q          <= 1'b0;
            wait_cnt      <= '0;
            mmu_addr_q    <= '0;
            mmu_wr_data_q <= '0;
            mmu_wr_ena_q  <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_rd_data_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wr_data;
                        f3_q     <= bus.req_funct3;
                        wr_q     <= bus.req_wr;
                        wait_cnt <= '0;
                        if (req_err) begin
                            state         <= RESP;
                            rsp_valid_q   <= 1'b1;
                            rsp_err_q     <= 1'b1;
                            rsp_rd_data_q <= '0;
                        end else if (bus.req_wr && bus.req_funct3 == 3'b010) begin
                            state         <= WRITE;
                            mmu_addr_q    <= {bus.req_addr[31:2], 2'b00};
                            mmu_wr_data_q <= bus.req_wr_data;
                            mmu_wr_ena_q  <= 1'b1;
                        end else begin
                            state      <= READ;
                            mmu_addr_q <= {bus.req_addr[31:2], 2'b00};
                        end
                    end
                end
                READ: begin
                    if (wait_cnt == WAIT_LAST) begin
                        if (wr_q) begin
                            state         <= WRITE;
                            mmu_wr_ena_q  <= 1'b1;
                            mmu_wr_data_q <= store_merge(bus.mmu_rd_data, wdata_q, f3_q, addr_q[1:0]);
                        end else begin
                            state         <= RESP;
                            mmu_addr_q    <= '0;
                            rsp_valid_q   <= 1'b1;
                            rsp_err_q     <= 1'b0;
                            rsp_rd_data_q <= load_extract(bus.mmu_rd_data, f3_q, addr_q[1:0]);
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                WRITE: begin
                    state         <= RESP;
                    mmu_addr_q    <= '0;
                    mmu_wr_data_q <= '0;
                    mmu_wr_ena_q  <= 1'b0;
                    rsp_valid_q   <= 1'b1;
                    rsp_err_q     <= 1'b0;
                    rsp_rd_data_q <= '0;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Ready and write strobe are forced low for as long as reset is held.
    assign bus.req_ready   = rstb && (state == IDLE);
    assign bus.mmu_wr_ena  = rstb && mmu_wr_ena_q;
    assign bus.mmu_addr    = mmu_addr_q;
    assign bus.mmu_wr_data = mmu_wr_data_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_rd_data = rsp_rd_data_q;
endmodule
